pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 202 ++++++++++++++++++++
 tb/tb_pc_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter sequencer with optional return stack
//
// Purpose:
//   Holds the 16-bit word-addressed program counter and selects the next
//   value each cycle. The priority order is HALT > JUMP > CALL > RET >
//   taken branch > sequential. A two-state FSM (RUN / HALTED) stops
//   execution on HALT. Only RESET leaves HALTED.
//
// Configuration macro:
//   PC_UNIT_RETURN_STACK_EN -- when defined, a STACK_DEPTH-entry LIFO of
//   return addresses is built and CALL/RET are honoured. When undefined,
//   CALL/RET are ignored, STACK_ERR is tied low and no storage exists.
//
// Parameters:
//   RESET_VECTOR - PC value loaded while RESET is high
//   STACK_DEPTH  - number of return-stack entries (power of two, 2..16)
//
// Ports:
//   CLK       in   rising-edge clock
//   RESET     in   asynchronous active-high reset
//   STALL     in   freeze all state this cycle
//   BRANCH    in   current instruction is branch-on-zero
//   ZERO      in   ALU zero flag
//   OFFSET    in   8-bit signed branch displacement
//   JUMP      in   unconditional jump to TARGET
//   CALL      in   jump to TARGET, push return address
//   RET       in   pop return address into PC
//   TARGET    in   16-bit absolute jump/call address
//   HALT      in   stop execution
//   PC        out  registered program counter
//   HALTED    out  registered, high while halted
//   TAKEN     out  registered one-cycle pulse after a non-sequential update
//   STACK_ERR out  registered sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          STACK_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH,
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  input  logic        JUMP,
  input  logic        CALL,
  input  logic        RET,
  input  logic [15:0] TARGET,
  input  logic        HALT,
  output logic [15:0] PC,
  output logic        HALTED,
  output logic        TAKEN,
  output logic        STACK_ERR
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_halted;
  logic        r_taken;

  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_branch;
  logic [15:0] w_pc_next;
  logic        w_taken_next;
  logic        w_halt_req;

  // Both sums are 16 bits wide, so they wrap modulo 2^16 naturally.
  assign w_pc_inc    = r_pc + 16'd1;
  assign w_pc_branch = r_pc + 16'd1 + {{8{OFFSET[7]}}, OFFSET};

`ifdef PC_UNIT_RETURN_STACK_EN
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  logic [15:0]     r_stack [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;          // number of valid entries
  logic            r_stack_err;

  logic             w_full;
  logic             w_empty;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;
  logic [15:0]      w_top;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = r_sp[IDX_W-1:0];
  // When full, the low bits of r_sp wrap to 0, so minus one still lands
  // on the last entry.
  assign w_top_idx  = r_sp[IDX_W-1:0] - 1'b1;
  assign w_top      = r_stack[w_top_idx];
`endif

  // Next-state selection. STALL and HALTED both keep every register as it
  // is. TAKEN defaults to 0, so it is a pulse and never a level.
  always_comb begin
    w_pc_next    = r_pc;
    w_taken_next = 1'b0;
    w_halt_req   = 1'b0;
`ifdef PC_UNIT_RETURN_STACK_EN
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
`endif
    if (r_state == ST_RUN && !STALL) begin
      if (HALT) begin
        w_halt_req = 1'b1;
      end else if (JUMP) begin
        w_pc_next    = TARGET;
        w_taken_next = 1'b1;
`ifdef PC_UNIT_RETURN_STACK_EN
      end else if (CALL) begin
        // The jump happens even on overflow. Only the push is dropped.
        w_pc_next    = TARGET;
        w_taken_next = 1'b1;
        if (w_full) begin
          w_err_set = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end else if (RET) begin
        if (w_empty) begin
          // On underflow, treat the instruction as sequential and flag it.
          w_pc_next = w_pc_inc;
          w_err_set = 1'b1;
        end else begin
          w_pc_next    = w_top;
          w_taken_next = 1'b1;
          w_pop        = 1'b1;
        end
`endif
      end else if (BRANCH && ZERO) begin
        w_pc_next    = w_pc_branch;
        w_taken_next = 1'b1;
      end else begin
        w_pc_next = w_pc_inc;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_VECTOR;
      r_halted <= 1'b0;
      r_taken  <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_taken <= w_taken_next;
      if (w_halt_req) begin
        r_state  <= ST_HALTED;
        r_halted <= 1'b1;
      end
    end
  end

`ifdef PC_UNIT_RETURN_STACK_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sp        <= '0;
      r_stack_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + 1'b1;
      end else if (w_pop) begin
        r_sp <= r_sp - 1'b1;
      end
      if (w_err_set) begin
        r_stack_err <= 1'b1;
      end
    end
  end

  // Storage needs no reset. Emptiness comes from r_sp alone.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign STACK_ERR = r_stack_err;
`else
  // CALL and RET have no effect in this build.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, CALL, RET};
  assign STACK_ERR   = 1'b0;
`endif

  assign PC     = r_pc;
  assign HALTED = r_halted;
  assign TAKEN  = r_taken;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit.
// Directed scenarios use literal expected values. A randomized phase checks
// every cycle against a behavioural model: an integer PC, a queue for the
// return stack and two flags.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  localparam logic [15:0] RV    = 16'h0000;
  localparam int          DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET, STALL, BRANCH, ZERO, JUMP, CALL, RET, HALT;
  logic [7:0]  OFFSET;
  logic [15:0] TARGET;
  logic [15:0] PC;
  logic        HALTED, TAKEN, STACK_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic        m_halted, m_taken, m_err;
  logic [15:0] m_stack[$];

`ifdef PC_UNIT_RETURN_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  pc_unit #(.RESET_VECTOR(RV), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH(BRANCH), .ZERO(ZERO),
    .OFFSET(OFFSET), .JUMP(JUMP), .CALL(CALL), .RET(RET), .TARGET(TARGET),
    .HALT(HALT), .PC(PC), .HALTED(HALTED), .TAKEN(TAKEN), .STACK_ERR(STACK_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_pc = RV; m_halted = 1'b0; m_taken = 1'b0; m_err = 1'b0;
    m_stack.delete();
  endtask

  // Applies the specification's rules to the inputs present at the edge.
  task automatic model_step();
    int t;
    if (RESET) begin
      model_reset();
      return;
    end
    m_taken = 1'b0;
    if (m_halted || STALL) return;
    if (HALT) begin
      m_halted = 1'b1;
    end else if (JUMP) begin
      m_pc = TARGET; m_taken = 1'b1;
    end else if (STACK_EN && CALL) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back(m_pc + 16'd1);
      m_pc = TARGET; m_taken = 1'b1;
    end else if (STACK_EN && RET) begin
      if (m_stack.size() == 0) begin
        m_err = 1'b1; m_pc = m_pc + 16'd1;
      end else begin
        m_pc = m_stack.pop_back(); m_taken = 1'b1;
      end
    end else if (BRANCH && ZERO) begin
      t = int'(m_pc) + 1 + int'($signed(OFFSET));
      m_pc = t[15:0]; m_taken = 1'b1;
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic clear_inputs();
    STALL = 0; BRANCH = 0; ZERO = 0; JUMP = 0; CALL = 0; RET = 0; HALT = 0;
    OFFSET = 8'h00; TARGET = 16'h0000;
  endtask

  // One clock: update the model from current inputs, then sample 1ns after the edge.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_to(input logic [15:0] addr);
    clear_inputs(); JUMP = 1; TARGET = addr; tick(); clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    n_cmp++; if (PC !== RV) begin n_bad++; $display("FAIL reset_pc: got %h want %h", PC, RV); end
    n_cmp++; if ({HALTED, TAKEN, STACK_ERR} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {HALTED, TAKEN, STACK_ERR}); end
    RESET = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (PC !== 16'(i)) begin n_bad++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, 16'(i)); end
      n_cmp++; if (TAKEN !== 1'b0) begin n_bad++; $display("FAIL seq_taken%0d: got %b want 0", i, TAKEN); end
    end
    $display("test_reset done: PC=%h", PC);
  endtask

  task automatic test_branch();
    go_to(16'h0010);
    n_cmp++; if (TAKEN !== 1'b1) begin n_bad++; $display("FAIL jump_taken: got %b want 1", TAKEN); end
    BRANCH = 1; ZERO = 1; OFFSET = 8'hFC; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h000D) begin n_bad++; $display("FAIL br_back_pc: got %h want 000d", PC); end
    n_cmp++; if (TAKEN !== 1'b1) begin n_bad++; $display("FAIL br_back_taken: got %b want 1", TAKEN); end
    tick();
    n_cmp++; if (PC !== 16'h000E || TAKEN !== 1'b0) begin n_bad++; $display("FAIL br_pulse: got pc=%h taken=%b want 000e/0", PC, TAKEN); end
    go_to(16'h0010);
    BRANCH = 1; ZERO = 0; OFFSET = 8'hFC; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0011 || TAKEN !== 1'b0) begin n_bad++; $display("FAIL br_not_taken: got pc=%h taken=%b want 0011/0", PC, TAKEN); end
    $display("test_branch done: PC=%h", PC);
  endtask

  task automatic test_wrap();
    go_to(16'hFFFF);
    tick();
    n_cmp++; if (PC !== 16'h0000 || TAKEN !== 1'b0) begin n_bad++; $display("FAIL wrap_inc: got pc=%h taken=%b want 0000/0", PC, TAKEN); end
    go_to(16'hFFFE);
    BRANCH = 1; ZERO = 1; OFFSET = 8'h01; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0000 || TAKEN !== 1'b1) begin n_bad++; $display("FAIL wrap_br: got pc=%h taken=%b want 0000/1", PC, TAKEN); end
    $display("test_wrap done: PC=%h", PC);
  endtask

  task automatic test_stall();
    go_to(16'h0040);
    STALL = 1; JUMP = 1; TARGET = 16'h0777;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (PC !== 16'h0040 || TAKEN !== 1'b0) begin n_bad++; $display("FAIL stall%0d: got pc=%h taken=%b want 0040/0", i, PC, TAKEN); end
    end
    STALL = 0; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0777 || TAKEN !== 1'b1) begin n_bad++; $display("FAIL stall_release: got pc=%h taken=%b want 0777/1", PC, TAKEN); end
    $display("test_stall done: PC=%h", PC);
  endtask

  task automatic test_halt();
    go_to(16'h0055);
    JUMP = 1; HALT = 1; TARGET = 16'h1234; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0055 || HALTED !== 1'b1 || TAKEN !== 1'b0) begin n_bad++; $display("FAIL halt: got pc=%h halted=%b taken=%b want 0055/1/0", PC, HALTED, TAKEN); end
    JUMP = 1; TARGET = 16'h5555; tick(); tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0055 || HALTED !== 1'b1 || TAKEN !== 1'b0) begin n_bad++; $display("FAIL halt_hold: got pc=%h halted=%b taken=%b want 0055/1/0", PC, HALTED, TAKEN); end
    // Asynchronous reset between edges
    RESET = 1; #1;
    model_reset();
    n_cmp++; if (PC !== RV || HALTED !== 1'b0) begin n_bad++; $display("FAIL halt_async_reset: got pc=%h halted=%b want %h/0", PC, HALTED, RV); end
    RESET = 0;
    tick();
    n_cmp++; if (PC !== RV + 16'd1) begin n_bad++; $display("FAIL post_reset_pc: got %h want %h", PC, RV + 16'd1); end
    $display("test_halt done: PC=%h", PC);
  endtask

`ifdef PC_UNIT_RETURN_STACK_EN
  task automatic test_stack();
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'h0101; exp_ret[1] = 16'h0101; exp_ret[2] = 16'h0101; exp_ret[3] = 16'h0021;
    go_to(16'h0020);
    for (int i = 1; i <= 5; i++) begin
      CALL = 1; TARGET = 16'h0100; tick(); clear_inputs();
      n_cmp++; if (PC !== 16'h0100 || TAKEN !== 1'b1) begin n_bad++; $display("FAIL call%0d: got pc=%h taken=%b want 0100/1", i, PC, TAKEN); end
      n_cmp++; if (STACK_ERR !== (i == 5)) begin n_bad++; $display("FAIL call%0d_err: got %b want %b", i, STACK_ERR, (i == 5)); end
    end
    for (int i = 0; i < 4; i++) begin
      RET = 1; tick(); clear_inputs();
      n_cmp++; if (PC !== exp_ret[i] || TAKEN !== 1'b1) begin n_bad++; $display("FAIL ret%0d: got pc=%h taken=%b want %h/1", i, PC, TAKEN, exp_ret[i]); end
    end
    RET = 1; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0022 || TAKEN !== 1'b0 || STACK_ERR !== 1'b1) begin n_bad++; $display("FAIL ret_underflow: got pc=%h taken=%b err=%b want 0022/0/1", PC, TAKEN, STACK_ERR); end
    // CALL and RET together act as CALL
    CALL = 1; RET = 1; TARGET = 16'h0300; tick(); clear_inputs();
    RET = 1; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0023) begin n_bad++; $display("FAIL call_ret_together: got %h want 0023", PC); end
    // Fill the stack, then reset: the stack must come back empty
    for (int i = 0; i < 4; i++) begin CALL = 1; TARGET = 16'h0200; tick(); clear_inputs(); end
    RESET = 1; #1; model_reset();
    n_cmp++; if (STACK_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", STACK_ERR); end
    RESET = 0;
    RET = 1; tick(); clear_inputs();
    n_cmp++; if (PC !== RV + 16'd1 || TAKEN !== 1'b0 || STACK_ERR !== 1'b1) begin n_bad++; $display("FAIL reset_empties_stack: got pc=%h taken=%b err=%b", PC, TAKEN, STACK_ERR); end
    $display("test_stack done: PC=%h", PC);
  endtask
`else
  task automatic test_stack();
    go_to(16'h0020);
    CALL = 1; TARGET = 16'h0100; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0021 || TAKEN !== 1'b0 || STACK_ERR !== 1'b0) begin n_bad++; $display("FAIL call_ignored: got pc=%h taken=%b err=%b want 0021/0/0", PC, TAKEN, STACK_ERR); end
    RET = 1; tick(); clear_inputs();
    n_cmp++; if (PC !== 16'h0022 || TAKEN !== 1'b0 || STACK_ERR !== 1'b0) begin n_bad++; $display("FAIL ret_ignored: got pc=%h taken=%b err=%b want 0022/0/0", PC, TAKEN, STACK_ERR); end
    $display("test_stack (disabled build) done: PC=%h", PC);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET  = ($urandom_range(0, 59) == 0);
      STALL  = ($urandom_range(0, 7) == 0);
      HALT   = ($urandom_range(0, 39) == 0);
      JUMP   = ($urandom_range(0, 7) == 0);
      CALL   = ($urandom_range(0, 5) == 0);
      RET    = ($urandom_range(0, 5) == 0);
      BRANCH = ($urandom_range(0, 2) == 0);
      ZERO   = 1'($urandom_range(0, 1));
      OFFSET = 8'($urandom);
      TARGET = 16'($urandom);
      tick();
      n_cmp++;
      if (PC !== m_pc || TAKEN !== m_taken || HALTED !== m_halted || STACK_ERR !== (STACK_EN && m_err)) begin
        n_bad++;
        $display("FAIL rand%0d: got pc=%h t=%b h=%b e=%b want pc=%h t=%b h=%b e=%b",
                 i, PC, TAKEN, HALTED, STACK_ERR, m_pc, m_taken, m_halted, STACK_EN && m_err);
      end
    end
    RESET = 0;
    clear_inputs();
    $display("test_random done: PC=%h", PC);
  endtask

  initial begin
    test_reset();
    test_branch();
    test_wrap();
    test_stall();
    test_halt();
    test_stack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
